fetch_queue: RTL

Instruction fetch front end that produces the instruction stream consumed by the decode stage. Holds the fetch PC, issues in-order word requests to instruction memory over a valid/ready request channel, buffers returned words with their PCs in a small FIFO, and presents the head entry as `Instr_D`/`PC_D`. It handles decode stalls and branch/jump redirects from execute, including discarding responses still in flight from the old stream.

---
 rtl/fetch_queue.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end. Holds the fetch PC, issues
// in-order word requests to instruction memory, buffers returned words with
// their PCs in a small FIFO and presents the head entry to decode. Redirects
// from execute flush the FIFO and discard responses still in flight.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a kept response arriving while the FIFO is empty is
//   forwarded combinationally to the decode outputs in the same cycle.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Stall_F,
  input  logic        Redirect_En_E,
  input  logic [31:0] PC_Target_E,
  output logic        IMEM_Req_Valid,
  output logic [31:0] IMEM_Req_Addr,
  input  logic        IMEM_Req_Ready,
  input  logic        IMEM_Rsp_Valid,
  input  logic [31:0] IMEM_Rsp_Data,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic        Instr_Valid_D
);

  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam int unsigned PW        = $clog2(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   cnt_w_t;
  typedef logic [PW-1:0] ptr_t;

  localparam cnt_w_t DEPTH_W = cnt_w_t'(DEPTH);

  // Sequential PC step; 32'hFFFF_FFFC wraps to zero.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // State
  logic [31:0] pc_f_r;
  logic [31:0] rsp_pc_r;
  cnt_t        occ_r;
  cnt_t        out_r;
  cnt_t        drop_r;
  ptr_t        rd_ptr_r;
  ptr_t        wr_ptr_r;
  logic [31:0] fifo_pc_r    [DEPTH];
  logic [31:0] fifo_instr_r [DEPTH];

  // Control
  logic        head_valid_s;
  logic        rsp_keep_s;
  logic        bypass_s;
  logic        instr_valid_s;
  logic        pop_s;
  logic        push_s;
  logic        fifo_pop_s;
  cnt_w_t      credit_s;
  logic        req_valid_s;
  logic        accept_s;

  // Next state
  logic [31:0] pc_f_nxt_s;
  logic [31:0] rsp_pc_nxt_s;
  cnt_t        occ_nxt_s;
  cnt_t        out_nxt_s;
  cnt_t        drop_nxt_s;
  ptr_t        rd_ptr_nxt_s;
  ptr_t        wr_ptr_nxt_s;

  // Head output
  logic [31:0] instr_d_s;
  logic [31:0] pc_d_s;

  // Handshake decode: keep/drop, pop, push and credit-based issue.
  always_comb begin
    head_valid_s = (occ_r != '0);
    rsp_keep_s   = IMEM_Rsp_Valid && (drop_r == '0) && !Redirect_En_E;
`ifdef FETCH_BYPASS_EN
    bypass_s     = rsp_keep_s && (occ_r == '0);
`else
    bypass_s     = 1'b0;
`endif
    instr_valid_s = head_valid_s || bypass_s;
    pop_s         = instr_valid_s && !Stall_F && !Redirect_En_E;
    // A bypassed word that is consumed immediately never enters the FIFO.
    push_s        = rsp_keep_s && !(bypass_s && pop_s);
    fifo_pop_s    = pop_s && head_valid_s;
    // FIFO entries plus in-flight requests may never exceed DEPTH.
    credit_s      = cnt_w_t'(occ_r) + cnt_w_t'(out_r) - cnt_w_t'(pop_s);
    req_valid_s   = RST_N && !Redirect_En_E && (credit_s < DEPTH_W);
    accept_s      = req_valid_s && IMEM_Req_Ready;
  end

  // Next-state for PCs, counters and pointers; redirect overrides everything.
  always_comb begin
    pc_f_nxt_s   = pc_f_r;
    rsp_pc_nxt_s = rsp_pc_r;
    occ_nxt_s    = occ_r;
    drop_nxt_s   = drop_r;
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    out_nxt_s    = out_r;

    if (Redirect_En_E) begin
      pc_f_nxt_s   = word_align(PC_Target_E);
      rsp_pc_nxt_s = word_align(PC_Target_E);
      occ_nxt_s    = '0;
      rd_ptr_nxt_s = '0;
      wr_ptr_nxt_s = '0;
      // Everything still outstanding after this cycle belongs to the old stream.
      if (IMEM_Rsp_Valid) begin
        drop_nxt_s = out_r - cnt_t'(1'b1);
      end else begin
        drop_nxt_s = out_r;
      end
    end else begin
      case ({push_s, fifo_pop_s})
        2'b10:   occ_nxt_s = occ_r + cnt_t'(1'b1);
        2'b01:   occ_nxt_s = occ_r - cnt_t'(1'b1);
        default: occ_nxt_s = occ_r;
      endcase
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + ptr_t'(1'b1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (fifo_pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + ptr_t'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (accept_s) begin
        pc_f_nxt_s = pc_next(pc_f_r);
      end else begin
        pc_f_nxt_s = pc_f_r;
      end
      if (rsp_keep_s) begin
        rsp_pc_nxt_s = pc_next(rsp_pc_r);
      end else begin
        rsp_pc_nxt_s = rsp_pc_r;
      end
      if (IMEM_Rsp_Valid && (drop_r != '0)) begin
        drop_nxt_s = drop_r - cnt_t'(1'b1);
      end else begin
        drop_nxt_s = drop_r;
      end
    end

    case ({accept_s, IMEM_Rsp_Valid})
      2'b10:   out_nxt_s = out_r + cnt_t'(1'b1);
      2'b01:   out_nxt_s = out_r - cnt_t'(1'b1);
      default: out_nxt_s = out_r;
    endcase
  end

  // State registers and FIFO storage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_f_r   <= RESET_PC;
      rsp_pc_r <= RESET_PC;
      occ_r    <= '0;
      out_r    <= '0;
      drop_r   <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_r[i]    <= 32'h0000_0000;
        fifo_instr_r[i] <= NOP_INSTR;
      end
    end else begin
      pc_f_r   <= pc_f_nxt_s;
      rsp_pc_r <= rsp_pc_nxt_s;
      occ_r    <= occ_nxt_s;
      out_r    <= out_nxt_s;
      drop_r   <= drop_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      if (push_s) begin
        fifo_pc_r[wr_ptr_r]    <= rsp_pc_r;
        fifo_instr_r[wr_ptr_r] <= IMEM_Rsp_Data;
      end
    end
  end

  // Head selection: bypassed response, FIFO head, or NOP when empty.
  always_comb begin
    if (bypass_s) begin
      instr_d_s = IMEM_Rsp_Data;
      pc_d_s    = rsp_pc_r;
    end else if (head_valid_s) begin
      instr_d_s = fifo_instr_r[rd_ptr_r];
      pc_d_s    = fifo_pc_r[rd_ptr_r];
    end else begin
      instr_d_s = NOP_INSTR;
      pc_d_s    = 32'h0000_0000;
    end
  end

  assign IMEM_Req_Valid = req_valid_s;
  assign IMEM_Req_Addr  = pc_f_r;
  assign Instr_D        = instr_d_s;
  assign PC_D           = pc_d_s;
  assign PC4_D          = pc_d_s + 32'd4;
  assign Instr_Valid_D  = instr_valid_s;

endmodule
